// File: rtl/stft_frame_loader.sv
// stft_frame_loader
//   Streams one STFT magnitude frame (ROWS x COLS pixels) into the BNN
//   classifier's MEM0. Each pixel is binarized against a per-frame threshold
//   and 28 pixels are packed into one row word (column 0 -> bit 0). Each
//   completed row is written to MEM0 at its row index. After the last row the
//   classifier is started, and input is held off until the classifier signals
//   completion through iDONE.
//
// Ports
//   iCLK, iRSTn         clock, asynchronous active-low reset
//   iCLR                synchronous clear back to IDLE (no pending write/start)
//   iPIX, iVALID, iSOF  pixel stream; iSOF marks the first pixel of a frame
//   oREADY              a pixel is accepted when iVALID && oREADY
//   iTHRESH             binarization threshold, captured on the SOF accept
//   oMEM0ADDR/WrDATA/Wr_EN  registered MEM0 write port (row index / row bits)
//   oSTART              one-cycle classifier start pulse
//   iDONE               classifier result write strobe, ends the WAIT phase
//   oBUSY               high from the SOF accept until iDONE is seen
//   oERR                (only with LOADER_ERR_EN) sticky error: frame restart
//                       mid-frame or pixel offered while START/WAIT
//
// Build option: define LOADER_ERR_EN to add the oERR port.

module stft_frame_loader #(
  parameter int PW   = 16,
  parameter int COLS = 28,
  parameter int ROWS = 36
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iCLR,
  input  logic [PW-1:0]   iPIX,
  input  logic            iVALID,
  input  logic            iSOF,
  output logic            oREADY,
  input  logic [PW-1:0]   iTHRESH,
  output logic [5:0]      oMEM0ADDR,
  output logic [COLS-1:0] oMEM0WrDATA,
  output logic            oMEM0Wr_EN,
  output logic            oSTART,
  input  logic            iDONE,
  output logic            oBUSY
`ifdef LOADER_ERR_EN
  ,
  output logic            oERR
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      col_q, col_d;
  logic [5:0]      row_q, row_d;
  logic [PW-1:0]   thr_q, thr_d;
  logic [COLS-1:0] shift_q, shift_d;
  logic [5:0]      wr_addr_q, wr_addr_d;
  logic [COLS-1:0] wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            start_q, start_d;
`ifdef LOADER_ERR_EN
  logic            err_q, err_d;
`endif

  logic ready_int;
  logic accept;
  logic sof_accept;
  logic pix_bit;
  logic sof_bit;

  assign ready_int  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = iVALID && ready_int;
  assign sof_accept = accept && iSOF;
  // Normal pixels use the latched threshold; the SOF pixel must already use
  // the threshold being captured with it.
  assign pix_bit    = (iPIX >= thr_q);
  assign sof_bit    = (iPIX >= iTHRESH);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    thr_d     = thr_q;
    shift_d   = shift_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    start_d   = 1'b0;
`ifdef LOADER_ERR_EN
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (sof_accept) begin
          // Frame start (or restart): any partial row is dropped unwritten.
`ifdef LOADER_ERR_EN
          if ((state_q == S_LOAD) && ((col_q != 5'd0) || (row_q != 6'd0))) begin
            err_d = 1'b1;
          end
`endif
          thr_d      = iTHRESH;
          shift_d    = '0;
          shift_d[0] = sof_bit;
          col_d      = 5'd1;
          row_d      = 6'd0;
          state_d    = S_LOAD;
        end else if (accept && (state_q == S_LOAD)) begin
          shift_d[col_q] = pix_bit;
          if (col_q == 5'(COLS - 1)) begin
            // Row complete: hand the word to the write register so the next
            // row can start filling in the write cycle itself.
            wr_data_d = shift_d;
            wr_addr_d = row_q;
            wr_en_d   = 1'b1;
            shift_d   = '0;
            col_d     = 5'd0;
            row_d     = row_q + 6'd1;
            if (row_q == 6'(ROWS - 1)) begin
              state_d = S_START;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end

      S_START: begin
        // First START cycle coincides with the last write strobe; the start
        // pulse is registered so it appears in the following cycle.
        if (start_q) begin
          state_d = S_WAIT;
        end else begin
          start_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (iDONE) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_ERR_EN
    if (iVALID && ((state_q == S_START) || (state_q == S_WAIT))) begin
      err_d = 1'b1;
    end
`endif

    if (iCLR) begin
      state_d = S_IDLE;
      col_d   = 5'd0;
      row_d   = 6'd0;
      shift_d = '0;
      wr_en_d = 1'b0;
      start_d = 1'b0;
`ifdef LOADER_ERR_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= S_IDLE;
      col_q     <= 5'd0;
      row_q     <= 6'd0;
      thr_q     <= '0;
      shift_q   <= '0;
      wr_addr_q <= 6'd0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      thr_q     <= thr_d;
      shift_q   <= shift_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      start_q   <= start_d;
    end
  end

`ifdef LOADER_ERR_EN
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign oERR = err_q;
`endif

  // Ready is forced low while reset is held even though the state is IDLE.
  assign oREADY      = iRSTn && ready_int;
  assign oMEM0ADDR   = wr_addr_q;
  assign oMEM0WrDATA = wr_data_q;
  assign oMEM0Wr_EN  = wr_en_q;
  assign oSTART      = start_q;
  assign oBUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_stft_frame_loader.sv
module tb_stft_frame_loader;

  logic        iCLK = 1'b0;
  logic        iRSTn, iCLR, iVALID, iSOF, iDONE;
  logic [15:0] iPIX, iTHRESH;
  logic        oREADY, oMEM0Wr_EN, oSTART, oBUSY;
  logic [5:0]  oMEM0ADDR;
  logic [27:0] oMEM0WrDATA;
`ifdef LOADER_ERR_EN
  logic        oERR;
`endif

  stft_frame_loader #(.PW(16), .COLS(28), .ROWS(36)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iPIX(iPIX), .iVALID(iVALID),
    .iSOF(iSOF), .oREADY(oREADY), .iTHRESH(iTHRESH), .oMEM0ADDR(oMEM0ADDR),
    .oMEM0WrDATA(oMEM0WrDATA), .oMEM0Wr_EN(oMEM0Wr_EN), .oSTART(oSTART),
    .iDONE(iDONE), .oBUSY(oBUSY)
`ifdef LOADER_ERR_EN
    , .oERR(oERR)
`endif
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [27:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  start_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe / start pulse pops the next expectation.
  initial begin
    wr_t e;
    int  s;
    forever begin
      @(negedge iCLK);
      if (iRSTn === 1'b1) begin
        if (oMEM0Wr_EN !== 1'b0) begin
          if (wr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: strobe addr=%0d data=0x%07h at cycle %0d, required none",
                     oMEM0ADDR, oMEM0WrDATA, cyc);
          end else begin
            e = wr_q.pop_front();
            $display("write addr=%0d data=0x%07h cycle=%0d", oMEM0ADDR, oMEM0WrDATA, cyc);
            chk("wr_addr", 32'(oMEM0ADDR), 32'(e.addr));
            chk("wr_data", 32'(oMEM0WrDATA), 32'(e.data));
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (oSTART !== 1'b0) begin
          if (start_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_start: pulse at cycle %0d, required none", cyc);
          end else begin
            s = start_q.pop_front();
            $display("start cycle=%0d", cyc);
            chk("start_cycle", 32'(cyc), 32'(s));
          end
        end
      end
    end
  end

  // Drive one pixel; returns the cycle in which it was accepted.
  task automatic send_pix(input logic [15:0] pix, input logic sof, input logic [15:0] thr,
                          input logic done, input logic clr, input bit gap, output int acc);
    int wait_n;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      iVALID = 1'b0;
      iSOF   = 1'b0;
      @(posedge iCLK);
      #1;
    end
    iVALID  = 1'b1;
    iPIX    = pix;
    iSOF    = sof;
    iTHRESH = thr;
    iDONE   = done;
    iCLR    = clr;
    acc     = -1;
    wait_n  = 0;
    while (acc < 0 && wait_n < 50) begin
      @(negedge iCLK);
      if (oREADY === 1'b1) acc = cyc;
      @(posedge iCLK);
      #1;
      wait_n++;
    end
    iDONE = 1'b0;
    iCLR  = 1'b0;
    iSOF  = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: oREADY=%0b, required 1 within 50 cycles", oREADY);
    end
  endtask

  // Hand-computed row words: mode 0 = all pixels equal to threshold,
  // mode 1 = row 0 alternating 5/20 against threshold 10, others 0.
  function automatic logic [27:0] exp_row(input int mode, input int r);
    if (mode == 0) return 28'hFFFFFFF;
    return (r == 0) ? 28'hAAAAAAA : 28'h0000000;
  endfunction

  task automatic send_frame(input int mode, input bit gap, input int stop_r, input int stop_c,
                            input bit clr_last, input bit done_mid);
    logic [15:0] thr, pix;
    bit          last;
    int          acc;
    thr = (mode == 0) ? 16'h0100 : 16'd10;
    for (int r = 0; r < 36; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (r == stop_r && c == stop_c) begin
          iVALID = 1'b0;
          return;
        end
        if (mode == 0) pix = 16'h0100;
        else if (r == 0) pix = (c % 2 == 1) ? 16'd20 : 16'd5;
        else pix = 16'd0;
        last = (r == 35) && (c == 27);
        send_pix(pix, (r == 0 && c == 0), thr, done_mid && r == 10 && c == 5,
                 clr_last && last, gap, acc);
        if (c == 27 && !(clr_last && last)) begin
          wr_q.push_back('{addr: r, data: exp_row(mode, r), cyc: acc + 1});
          if (last) start_q.push_back(acc + 2);
        end
      end
    end
    iVALID = 1'b0;
  endtask

  // Hold pixels (with SOF) on the input through START/WAIT, then release with iDONE.
  task automatic finish_frame();
    iVALID = 1'b1;
    iSOF   = 1'b1;
    iPIX   = 16'h0100;
    repeat (4) begin
      @(negedge iCLK);
      chk("wait_ready", 32'(oREADY), 32'd0);
      chk("wait_busy", 32'(oBUSY), 32'd1);
      @(posedge iCLK);
      #1;
    end
    iVALID = 1'b0;
    iSOF   = 1'b0;
    iDONE  = 1'b1;
    @(posedge iCLK);
    #1;
    iDONE = 1'b0;
    @(negedge iCLK);
    chk("done_ready", 32'(oREADY), 32'd1);
    chk("done_busy", 32'(oBUSY), 32'd0);
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    iRSTn = 1'b0; iCLR = 1'b0; iVALID = 1'b0; iSOF = 1'b0; iDONE = 1'b0;
    iPIX = 16'd0; iTHRESH = 16'd0;

    // Reset values
    repeat (2) @(negedge iCLK);
    chk("rst_ready", 32'(oREADY), 32'd0);
    chk("rst_addr", 32'(oMEM0ADDR), 32'd0);
    chk("rst_data", 32'(oMEM0WrDATA), 32'd0);
    chk("rst_wren", 32'(oMEM0Wr_EN), 32'd0);
    chk("rst_start", 32'(oSTART), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
`ifdef LOADER_ERR_EN
    chk("rst_err", 32'(oERR), 32'd0);
`endif
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    @(negedge iCLK);
    chk("rel_ready", 32'(oREADY), 32'd1);
    chk("rel_busy", 32'(oBUSY), 32'd0);
    @(posedge iCLK);
    #1;

    // Full frame, all ones, no gaps
    send_frame(0, 1'b0, -1, -1, 1'b0, 1'b0);
    finish_frame();
`ifdef LOADER_ERR_EN
    @(negedge iCLK);
    chk("overrun_err", 32'(oERR), 32'd1);
    @(posedge iCLK);
    #1;
`endif

    // Alternating row 0, gaps, iDONE pulsed mid-frame
    send_frame(1, 1'b1, -1, -1, 1'b0, 1'b1);
    finish_frame();

    // All-ones frame again with gaps
    send_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);
    finish_frame();

    // Clear coincident with the last accept: no row-35 write, no start
    send_frame(0, 1'b0, -1, -1, 1'b1, 1'b0);
    @(negedge iCLK);
    chk("clr_ready", 32'(oREADY), 32'd1);
    chk("clr_busy", 32'(oBUSY), 32'd0);
`ifdef LOADER_ERR_EN
    chk("clr_err", 32'(oERR), 32'd0);
`endif
    repeat (4) @(posedge iCLK);
    #1;

    // Restart at row 3 col 10 with a new threshold
    send_frame(0, 1'b0, 3, 10, 1'b0, 1'b0);
    send_frame(1, 1'b0, -1, -1, 1'b0, 1'b0);
`ifdef LOADER_ERR_EN
    @(negedge iCLK);
    chk("restart_err", 32'(oERR), 32'd1);
    @(posedge iCLK);
    #1;
`endif
    finish_frame();

    repeat (5) @(posedge iCLK);
    @(negedge iCLK);
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    chk("start_queue_empty", 32'(start_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
